// File: rtl/mag_cal_pkg.sv
// Shared types and limits for the magnetometer hard-iron calibration sequencer.
package mag_cal_pkg;

  localparam int unsigned DEFAULT_W   = 24;
  localparam int unsigned CAL_LEN_MIN = 4;
  localparam int unsigned CAL_LEN_MAX = 20;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StAcq,
    StCompute,
    StCheck
  } cal_state_e;

  function automatic logic [4:0] clamp_len(input logic [4:0] len);
    if (len < 5'(CAL_LEN_MIN)) return 5'(CAL_LEN_MIN);
    if (len > 5'(CAL_LEN_MAX)) return 5'(CAL_LEN_MAX);
    return len;
  endfunction

endpackage

// File: rtl/minmax_tracker.sv
// Per-axis signed min/max tracker: load_i seeds both extremes, update_i widens them.
module minmax_tracker
  import mag_cal_pkg::*;
#(
  parameter int unsigned W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         update_i,
  input  logic [W-1:0] sample_i,
  output logic [W-1:0] min_o,
  output logic [W-1:0] max_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_o <= '0;
      max_o <= '0;
    end else if (load_i) begin
      min_o <= sample_i;
      max_o <= sample_i;
    end else if (update_i) begin
      if ($signed(sample_i) < $signed(min_o)) min_o <= sample_i;
      if ($signed(sample_i) > $signed(max_o)) max_o <= sample_i;
    end
  end

endmodule

// File: rtl/mag_cal_sequencer.sv
// Hard-iron calibration sequencer: settle, per-axis min/max acquisition, offset/span compute.
// Optional watchdog between samples is enabled by defining MAG_CAL_TIMEOUT_EN.
module mag_cal_sequencer
  import mag_cal_pkg::*;
#(
  parameter int unsigned W           = DEFAULT_W,
  parameter int unsigned SETTLE      = 16,
  parameter int unsigned TIMEOUT_CYC = 1048576
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cal_start,
  input  logic         cal_abort,
  input  logic [4:0]   cal_len_log2,
  input  logic [W-1:0] min_span,
  input  logic         sample_valid,
  input  logic [W-1:0] in_x,
  input  logic [W-1:0] in_y,
  input  logic [W-1:0] in_z,
  output logic         cal_busy,
  output logic         cal_done,
  output logic         cal_error,
  output logic         cal_timeout,
  output logic         offset_wr,
  output logic [W-1:0] cal_off_x,
  output logic [W-1:0] cal_off_y,
  output logic [W-1:0] cal_off_z,
  output logic [W:0]   span_x,
  output logic [W:0]   span_y,
  output logic [W:0]   span_z
);

  localparam int unsigned CW = CAL_LEN_MAX + 1;
  localparam logic [CW-1:0] SettleLast = CW'(SETTLE - 1);

  cal_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic [4:0]    len_q;
  logic [CW-1:0] acq_last;

  logic         acq_sample, trk_load, trk_update;
  logic [W-1:0] min_x, max_x, min_y, max_y, min_z, max_z;
  logic [W-1:0] sel_max, sel_min;
  logic [W:0]   sum, diff;
  logic         span_ok;
  logic         timeout_hit;

  assign acq_last   = (CW'(1) << len_q) - CW'(1);
  assign acq_sample = (state_q == StAcq) && sample_valid && !cal_abort;
  assign trk_load   = acq_sample && (cnt_q == '0);
  assign trk_update = acq_sample && (cnt_q != '0);

  minmax_tracker #(.W(W)) u_trk_x (
    .clk(clk), .rst_n(rst_n), .load_i(trk_load), .update_i(trk_update),
    .sample_i(in_x), .min_o(min_x), .max_o(max_x)
  );
  minmax_tracker #(.W(W)) u_trk_y (
    .clk(clk), .rst_n(rst_n), .load_i(trk_load), .update_i(trk_update),
    .sample_i(in_y), .min_o(min_y), .max_o(max_y)
  );
  minmax_tracker #(.W(W)) u_trk_z (
    .clk(clk), .rst_n(rst_n), .load_i(trk_load), .update_i(trk_update),
    .sample_i(in_z), .min_o(min_z), .max_o(max_z)
  );

  // One sum/difference unit shared by the three axes; cnt_q selects the axis in COMPUTE.
  always_comb begin
    sel_max = max_x;
    sel_min = min_x;
    case (cnt_q[1:0])
      2'd1: begin
        sel_max = max_y;
        sel_min = min_y;
      end
      2'd2: begin
        sel_max = max_z;
        sel_min = min_z;
      end
      default: ;
    endcase
  end

  assign sum  = {sel_max[W-1], sel_max} + {sel_min[W-1], sel_min};
  assign diff = {sel_max[W-1], sel_max} - {sel_min[W-1], sel_min};

  assign span_ok = (span_x >= {1'b0, min_span}) && (span_y >= {1'b0, min_span}) &&
                   (span_z >= {1'b0, min_span});

`ifdef MAG_CAL_TIMEOUT_EN
  localparam int unsigned WDW = $clog2(TIMEOUT_CYC + 1);
  logic [WDW-1:0] wdog_q;
  logic           waiting;

  assign waiting     = (state_q == StSettle) || (state_q == StAcq);
  assign timeout_hit = waiting && !sample_valid && (wdog_q == WDW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else if (!waiting || sample_valid) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_q + WDW'(1);
    end
  end
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign timeout_hit        = 1'b0;
  assign cal_timeout        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      len_q     <= '0;
      cal_busy  <= 1'b0;
      cal_done  <= 1'b0;
      cal_error <= 1'b0;
`ifdef MAG_CAL_TIMEOUT_EN
      cal_timeout <= 1'b0;
`endif
      offset_wr <= 1'b0;
      cal_off_x <= '0;
      cal_off_y <= '0;
      cal_off_z <= '0;
      span_x    <= '0;
      span_y    <= '0;
      span_z    <= '0;
    end else begin
      offset_wr <= 1'b0;
      if (state_q != StIdle && cal_abort) begin
        state_q   <= StIdle;
        cal_busy  <= 1'b0;
        cal_error <= 1'b1;
      end else if (timeout_hit) begin
        state_q   <= StIdle;
        cal_busy  <= 1'b0;
        cal_error <= 1'b1;
`ifdef MAG_CAL_TIMEOUT_EN
        cal_timeout <= 1'b1;
`endif
      end else begin
        unique case (state_q)
          StIdle: begin
            if (cal_start && !cal_abort) begin
              state_q   <= StSettle;
              cnt_q     <= '0;
              len_q     <= clamp_len(cal_len_log2);
              cal_busy  <= 1'b1;
              cal_done  <= 1'b0;
              cal_error <= 1'b0;
`ifdef MAG_CAL_TIMEOUT_EN
              cal_timeout <= 1'b0;
`endif
            end
          end
          StSettle: begin
            if (sample_valid) begin
              if (cnt_q == SettleLast) begin
                state_q <= StAcq;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
          end
          StAcq: begin
            if (sample_valid) begin
              if (cnt_q == acq_last) begin
                state_q <= StCompute;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
          end
          StCompute: begin
            case (cnt_q[1:0])
              2'd0: begin
                cal_off_x <= sum[W:1];
                span_x    <= diff;
              end
              2'd1: begin
                cal_off_y <= sum[W:1];
                span_y    <= diff;
              end
              default: begin
                cal_off_z <= sum[W:1];
                span_z    <= diff;
              end
            endcase
            if (cnt_q[1:0] == 2'd2) begin
              state_q <= StCheck;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          StCheck: begin
            state_q   <= StIdle;
            cal_busy  <= 1'b0;
            offset_wr <= span_ok;
            cal_done  <= span_ok;
            cal_error <= !span_ok;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mag_cal_sequencer.sv
// Self-checking bench for mag_cal_sequencer: table of calibration runs plus corner sequences.
module tb_mag_cal_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cal_start = 1'b0;
  logic        cal_abort = 1'b0;
  logic [4:0]  cal_len_log2 = 5'd4;
  logic [23:0] min_span = '0;
  logic        sample_valid = 1'b0;
  logic [23:0] in_x = '0, in_y = '0, in_z = '0;
  logic        cal_busy, cal_done, cal_error, cal_timeout, offset_wr;
  logic [23:0] cal_off_x, cal_off_y, cal_off_z;
  logic [24:0] span_x, span_y, span_z;

  mag_cal_sequencer #(.W(24), .SETTLE(16), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst_n(rst_n), .cal_start(cal_start), .cal_abort(cal_abort),
    .cal_len_log2(cal_len_log2), .min_span(min_span), .sample_valid(sample_valid),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .cal_busy(cal_busy), .cal_done(cal_done),
    .cal_error(cal_error), .cal_timeout(cal_timeout), .offset_wr(offset_wr),
    .cal_off_x(cal_off_x), .cal_off_y(cal_off_y), .cal_off_z(cal_off_z),
    .span_x(span_x), .span_y(span_y), .span_z(span_z)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] len;
    int         n;
    longint     x_lo, x_hi, y_lo, y_hi, z_lo, z_hi;
    bit         desc;
    longint     mspan;
    longint     e_ox, e_oy, e_oz, e_sx, e_sy, e_sz;
    bit         e_pass;
  } vec_t;

  vec_t vecs[6];
  int   checks = 0;
  int   failures = 0;
  int   wr_cnt = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (offset_wr) wr_cnt++;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic send(input longint x, input longint y, input longint z);
    sample_valid = 1'b1;
    in_x = 24'(x);
    in_y = 24'(y);
    in_z = 24'(z);
    tick();
    sample_valid = 1'b0;
  endtask

  // Length changed right after start must not affect the run.
  task automatic do_start(input logic [4:0] len);
    cal_start = 1'b1;
    cal_len_log2 = len;
    tick();
    cal_start = 1'b0;
    cal_len_log2 = 5'd9;
  endtask

  task automatic settle_junk(input int cnt);
    for (int i = 0; i < cnt; i++) send(64'sd8000000, -64'sd8000000, 64'sd4000000);
  endtask

  function automatic longint interp(input longint lo, input longint hi, input bit desc,
                                    input int i, input int n);
    longint frac;
    frac = (longint'(i) * (hi - lo)) / longint'(n - 1);
    return desc ? hi - frac : lo + frac;
  endfunction

  task automatic sweep(input vec_t v, input int first, input int last);
    for (int i = first; i <= last; i++)
      send(interp(v.x_lo, v.x_hi, v.desc, i, v.n), interp(v.y_lo, v.y_hi, v.desc, i, v.n),
           interp(v.z_lo, v.z_hi, v.desc, i, v.n));
  endtask

  task automatic finish_checks(input vec_t v, input string tag);
    for (int k = 0; k < 3; k++) tick();
    check({tag, "_wr_early"}, wr_cnt, 0);
    tick();
    check({tag, "_wr_at4"}, longint'(offset_wr), longint'(v.e_pass));
    tick();
    tick();
    check({tag, "_wr_total"}, wr_cnt, longint'(v.e_pass));
    check({tag, "_done"}, longint'(cal_done), longint'(v.e_pass));
    check({tag, "_error"}, longint'(cal_error), longint'(!v.e_pass));
    check({tag, "_busy"}, longint'(cal_busy), 0);
    check({tag, "_offx"}, longint'($signed(cal_off_x)), v.e_ox);
    check({tag, "_offy"}, longint'($signed(cal_off_y)), v.e_oy);
    check({tag, "_offz"}, longint'($signed(cal_off_z)), v.e_oz);
    check({tag, "_spanx"}, longint'(span_x), v.e_sx);
    check({tag, "_spany"}, longint'(span_y), v.e_sy);
    check({tag, "_spanz"}, longint'(span_z), v.e_sz);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    min_span = 24'(v.mspan);
    do_start(v.len);
    check({tag, "_busy_start"}, longint'(cal_busy), 1);
    check({tag, "_err_clr"}, longint'(cal_error), 0);
    settle_junk(16);
    wr_cnt = 0;
    sweep(v, 0, v.n - 1);
    finish_checks(v, tag);
  endtask

  initial begin
    //          len    n   x_lo      x_hi     y_lo     y_hi     z_lo      z_hi   desc mspan
    vecs[0] = '{5'd4, 16, -500, 300, -200, 200, 1000, 1400, 1'b0, 100,
                -100, 0, 1200, 800, 400, 400, 1'b1};
    vecs[1] = '{5'd4, 16, -6, -3, 0, 1, -1, 0, 1'b1, 0,
                -5, 0, -1, 3, 1, 1, 1'b1};
    vecs[2] = '{5'd2, 16, -8388608, 8388607, 8388607, 8388607, -8388608, -8388608, 1'b0, 0,
                -1, 8388607, -8388608, 16777215, 0, 0, 1'b1};
    vecs[3] = '{5'd4, 16, -100, 100, -100, 100, 42, 42, 1'b0, 10,
                0, 0, 42, 200, 200, 0, 1'b0};
    vecs[4] = '{5'd5, 32, 0, 10, 0, 10, 5, 15, 1'b1, 10,
                5, 5, 10, 10, 10, 10, 1'b1};
    vecs[5] = '{5'd0, 16, 0, 10, 0, 11, 0, 11, 1'b0, 11,
                5, 5, 5, 10, 11, 11, 1'b0};

    // Reset state
    #1;
    check("rst_busy", longint'(cal_busy), 0);
    check("rst_done", longint'(cal_done), 0);
    check("rst_error", longint'(cal_error), 0);
    check("rst_timeout", longint'(cal_timeout), 0);
    check("rst_wr", longint'(offset_wr), 0);
    check("rst_offx", longint'(cal_off_x), 0);
    check("rst_spanz", longint'(span_z), 0);
    tick();
    #2 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Abort coinciding with the final acquisition sample
    min_span = 24'd100;
    do_start(5'd4);
    settle_junk(16);
    wr_cnt = 0;
    sweep(vecs[0], 0, 14);
    cal_abort = 1'b1;
    sweep(vecs[0], 15, 15);
    cal_abort = 1'b0;
    check("abort_error", longint'(cal_error), 1);
    check("abort_busy", longint'(cal_busy), 0);
    for (int k = 0; k < 6; k++) tick();
    check("abort_no_wr", wr_cnt, 0);
    check("abort_done", longint'(cal_done), 0);
    run_vec(vecs[0], "post_abort");

    // Start and abort together in IDLE: start ignored, flags untouched
    cal_start = 1'b1;
    cal_abort = 1'b1;
    tick();
    cal_start = 1'b0;
    cal_abort = 1'b0;
    tick();
    check("startabort_busy", longint'(cal_busy), 0);
    check("startabort_done", longint'(cal_done), 1);

    // Start-cycle sample not counted; second start during SETTLE ignored
    min_span = 24'd100;
    cal_start = 1'b1;
    cal_len_log2 = 5'd4;
    sample_valid = 1'b1;
    in_x = 24'd8000000;
    in_y = 24'd8000000;
    in_z = 24'd8000000;
    tick();
    cal_start = 1'b0;
    sample_valid = 1'b0;
    settle_junk(5);
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    check("restart_busy", longint'(cal_busy), 1);
    settle_junk(11);
    wr_cnt = 0;
    sweep(vecs[0], 0, 15);
    finish_checks(vecs[0], "busy_start");

    // Samples stop mid-acquisition
    do_start(5'd4);
    settle_junk(16);
    sweep(vecs[0], 0, 2);
    for (int k = 0; k < 63; k++) tick();
    check("stall63_busy", longint'(cal_busy), 1);
    check("stall63_timeout", longint'(cal_timeout), 0);
    tick();
`ifdef MAG_CAL_TIMEOUT_EN
    check("stall64_timeout", longint'(cal_timeout), 1);
    check("stall64_error", longint'(cal_error), 1);
    check("stall64_busy", longint'(cal_busy), 0);
`else
    for (int k = 0; k < 10; k++) tick();
    check("stall_busy", longint'(cal_busy), 1);
    check("stall_timeout", longint'(cal_timeout), 0);
`endif
    cal_abort = 1'b1;
    tick();
    cal_abort = 1'b0;
    check("stall_abort_busy", longint'(cal_busy), 0);
    check("stall_abort_error", longint'(cal_error), 1);

    // Asynchronous reset mid-acquisition
    do_start(5'd4);
    settle_junk(16);
    sweep(vecs[0], 0, 9);
    #3 rst_n = 1'b0;
    #1;
    check("areset_busy", longint'(cal_busy), 0);
    check("areset_error", longint'(cal_error), 0);
    check("areset_offx", longint'(cal_off_x), 0);
    #2 rst_n = 1'b1;
    wr_cnt = 0;
    sweep(vecs[0], 10, 15);
    for (int k = 0; k < 8; k++) tick();
    check("areset_no_wr", wr_cnt, 0);
    check("areset_done", longint'(cal_done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
